// File: rtl/ingress_rr_sched.sv
// Round-robin ingress scheduler: grants one of four PHY FIFOs to the frame decoder,
// with an ack timeout on offered grants and a watchdog on active frames.
module ingress_rr_sched #(
  parameter int unsigned ACK_TO  = 15,
  parameter int unsigned MAX_CYC = 4095
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic [3:0] req,
  input  logic       h_fifo_full,
  input  logic       b_fifo_afull,
  input  logic       ack,
  input  logic       done,
  output logic       gnt_valid,
  output logic [1:0] gnt_id,
  output logic [3:0] gnt_onehot,
  output logic       abort,
  output logic [7:0] abort_cnt
);

  localparam int unsigned WaitW = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;

  typedef enum logic [1:0] {StIdle, StOffer, StActive, StHoldoff} state_e;

  state_e             state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [1:0]         gnt_id_q, gnt_id_d;
  logic               gnt_valid_q, gnt_valid_d;
  logic               abort_q, abort_d;
  logic [7:0]         abort_cnt_q, abort_cnt_d;
  logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [11:0]        wd_cnt_q, wd_cnt_d;

  logic               eligible;
  logic               pick_found;
  logic [1:0]         pick_id;
  logic [1:0]         idx;

  assign eligible = (|req) & ~h_fifo_full & ~b_fifo_afull;

  // Search starts one past the last served port so every requester gets a turn.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = ptr_q;
    idx        = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!pick_found && req[idx]) begin
        pick_found = 1'b1;
        pick_id    = idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    abort_d     = 1'b0;
    abort_cnt_d = abort_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    wd_cnt_d    = wd_cnt_q;

    unique case (state_q)
      StIdle: begin
        gnt_valid_d = 1'b0;
        if (eligible) begin
          gnt_id_d    = pick_id;
          gnt_valid_d = 1'b1;
          wait_cnt_d  = '0;
          state_d     = StOffer;
        end
      end
      StOffer: begin
        if (ack) begin
          ptr_d    = gnt_id_q;
          wd_cnt_d = '0;
          state_d  = StActive;
        end else if (!req[gnt_id_q] || wait_cnt_q == WaitW'(ACK_TO - 1)) begin
          // Withdrawn port still counts as served so it cannot lock others out.
          gnt_valid_d = 1'b0;
          ptr_d       = gnt_id_q;
          state_d     = StHoldoff;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      StActive: begin
        if (done) begin
          gnt_valid_d = 1'b0;
          state_d     = StHoldoff;
        end else if (wd_cnt_q == 12'(MAX_CYC - 1)) begin
          abort_d     = 1'b1;
          gnt_valid_d = 1'b0;
          if (abort_cnt_q != 8'hff) abort_cnt_d = abort_cnt_q + 8'd1;
          state_d     = StHoldoff;
        end else begin
          wd_cnt_d = wd_cnt_q + 12'd1;
        end
      end
      StHoldoff: begin
        gnt_valid_d = 1'b0;
        state_d     = StIdle;
      end
      default: begin
        gnt_valid_d = 1'b0;
        state_d     = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= StIdle;
      ptr_q       <= 2'd3;
      gnt_id_q    <= 2'd0;
      gnt_valid_q <= 1'b0;
      abort_q     <= 1'b0;
      abort_cnt_q <= 8'd0;
      wait_cnt_q  <= '0;
      wd_cnt_q    <= 12'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      abort_q     <= abort_d;
      abort_cnt_q <= abort_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
    end
  end

  assign gnt_valid  = gnt_valid_q;
  assign gnt_id     = gnt_id_q;
  assign abort      = abort_q;
  assign abort_cnt  = abort_cnt_q;
  assign gnt_onehot = gnt_valid_q ? (4'b0001 << gnt_id_q) : 4'b0000;

endmodule

// File: tb/tb_ingress_rr_sched.sv
// Bench for ingress_rr_sched: vector table, directed corner sequences and a
// randomized run checked every cycle against a transaction-level reference model.
module tb_ingress_rr_sched;

  localparam int unsigned ACK_TO  = 15;
  localparam int unsigned MAX_CYC = 20;

  logic       clk = 1'b0;
  logic       arst_n;
  logic [3:0] req;
  logic       h_fifo_full, b_fifo_afull, ack, done;
  logic       gnt_valid, abort;
  logic [1:0] gnt_id;
  logic [3:0] gnt_onehot;
  logic [7:0] abort_cnt;

  ingress_rr_sched #(.ACK_TO(ACK_TO), .MAX_CYC(MAX_CYC)) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .req          (req),
    .h_fifo_full  (h_fifo_full),
    .b_fifo_afull (b_fifo_afull),
    .ack          (ack),
    .done         (done),
    .gnt_valid    (gnt_valid),
    .gnt_id       (gnt_id),
    .gnt_onehot   (gnt_onehot),
    .abort        (abort),
    .abort_cnt    (abort_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 offered, 2 in frame, 3 gap; m_age counts cycles spent.
  int m_mode, m_last, m_id, m_age, m_cnt;
  bit m_valid, m_abort;

  task automatic model_reset();
    m_mode = 0; m_last = 3; m_id = 0; m_age = 0; m_cnt = 0; m_valid = 0; m_abort = 0;
  endtask

  task automatic model_step();
    m_abort = 0;
    case (m_mode)
      0: begin
        m_valid = 0;
        if (req != 4'd0 && !h_fifo_full && !b_fifo_afull) begin
          for (int k = 1; k <= 4; k++) begin
            int p;
            p = (m_last + k) % 4;
            if (req[p]) begin
              m_id = p;
              break;
            end
          end
          m_valid = 1; m_mode = 1; m_age = 0;
        end
      end
      1: begin
        m_age++;
        if (ack) begin
          m_mode = 2; m_last = m_id; m_age = 0;
        end else if (!req[m_id] || m_age == int'(ACK_TO)) begin
          m_valid = 0; m_last = m_id; m_mode = 3;
        end
      end
      2: begin
        m_age++;
        if (done) begin
          m_valid = 0; m_mode = 3;
        end else if (m_age == int'(MAX_CYC)) begin
          m_abort = 1; m_valid = 0; m_mode = 3;
          m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        end
      end
      default: m_mode = 0;
    endcase
  endtask

  task automatic check_model();
    check("model_valid", gnt_valid, m_valid);
    check("model_id", gnt_id, m_id);
    check("model_onehot", gnt_onehot, m_valid ? (32'd1 << m_id) : 32'd0);
    check("model_abort", abort, m_abort);
    check("model_abort_cnt", abort_cnt, m_cnt);
  endtask

  // Inputs change on negedge; DUT and model both see them at the following posedge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic set_in(input logic [3:0] r, input logic hf, input logic ba,
                        input logic a, input logic d);
    req = r; h_fifo_full = hf; b_fifo_afull = ba; ack = a; done = d;
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    set_in(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0] req;
    logic       hf, ba, ack, done;
    logic       ev;
    logic [1:0] eid;
  } vec_t;

  vec_t tv[17];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, gap, n_ab;
    logic [1:0] exp_id;

    tv[0]  = '{4'b0101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    tv[1]  = '{4'b0101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    tv[2]  = '{4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
    tv[3]  = '{4'b0101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0};
    tv[4]  = '{4'b0101, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
    tv[5]  = '{4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    tv[6]  = '{4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2};
    tv[7]  = '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2};
    tv[8]  = '{4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2};
    tv[9]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2};
    tv[10] = '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2};
    tv[11] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2};
    tv[12] = '{4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2};
    tv[13] = '{4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
    tv[14] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    tv[15] = '{4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    tv[16] = '{4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1};

    arst_n = 1'b0;
    set_in(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #2;
    check("rst_valid", gnt_valid, 0);
    check("rst_id", gnt_id, 0);
    check("rst_onehot", gnt_onehot, 0);
    check("rst_abort", abort, 0);
    check("rst_abort_cnt", abort_cnt, 0);
    do_reset();

    for (int i = 0; i < 17; i++) begin
      set_in(tv[i].req, tv[i].hf, tv[i].ba, tv[i].ack, tv[i].done);
      tick();
      check($sformatf("vec%0d_valid", i), gnt_valid, tv[i].ev);
      check($sformatf("vec%0d_id", i), gnt_id, tv[i].eid);
      check($sformatf("vec%0d_onehot", i), gnt_onehot,
            tv[i].ev ? (32'd1 << tv[i].eid) : 32'd0);
      check($sformatf("vec%0d_abort", i), abort, 0);
    end

    // Fair rotation with all ports requesting.
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      gap = 0;
      n = 0;
      while (!gnt_valid && n < 10) begin
        gap++; n++;
        tick();
      end
      check($sformatf("rr%0d_valid", g), gnt_valid, 1);
      exp_id = 2'(g);
      check($sformatf("rr%0d_id", g), gnt_id, exp_id);
      if (g > 0) check($sformatf("rr%0d_gap_ok", g), gap >= 1, 1);
      ack = 1'b1; tick(); ack = 1'b0;
      done = 1'b1; tick(); done = 1'b0;
      check($sformatf("rr%0d_released", g), gnt_valid, 0);
    end

    // Ack timeout withdraws the offer, then the same port is re-offered.
    do_reset();
    req = 4'b0100;
    tick();
    n = 0;
    while (gnt_valid && n < 40) begin
      n++;
      tick();
    end
    check("ackto_offer_cycles", n, ACK_TO);
    n = 0;
    while (!gnt_valid && n < 10) begin
      n++;
      tick();
    end
    check("ackto_reoffer_valid", gnt_valid, 1);
    check("ackto_reoffer_id", gnt_id, 2);

    // Watchdog abort latency, single-cycle pulse and saturation.
    do_reset();
    req = 4'b0001; ack = 1'b1;
    tick();
    tick();
    n = 0;
    while (!abort && n < 40) begin
      n++;
      tick();
    end
    check("wd_latency", n, MAX_CYC);
    check("wd_abort_cnt1", abort_cnt, 1);
    tick();
    check("wd_pulse_width", abort, 0);
    n_ab = 1;
    n = 0;
    while (n_ab < 305 && n < 9000) begin
      n++;
      tick();
      if (abort) n_ab++;
    end
    check("wd_abort_count_reached", n_ab, 305);
    check("wd_saturate", abort_cnt, 255);

    // done on the expiry cycle wins over the watchdog.
    do_reset();
    req = 4'b0001; ack = 1'b1;
    tick();
    tick();
    ack = 1'b0;
    repeat (MAX_CYC - 1) tick();
    check("coinc_still_active", gnt_valid, 1);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("coinc_abort", abort, 0);
    check("coinc_valid", gnt_valid, 0);
    check("coinc_abort_cnt", abort_cnt, 0);

    // Asynchronous reset in the middle of a frame.
    do_reset();
    req = 4'b0010;
    tick();
    ack = 1'b1; tick(); ack = 1'b0;
    repeat (3) tick();
    check("mid_active_valid", gnt_valid, 1);
    check("mid_active_id", gnt_id, 1);
    #2;
    arst_n = 1'b0;
    model_reset();
    #1;
    check("arst_valid", gnt_valid, 0);
    check("arst_id", gnt_id, 0);
    check("arst_onehot", gnt_onehot, 0);
    check("arst_abort", abort, 0);
    check("arst_abort_cnt", abort_cnt, 0);
    @(negedge clk);
    arst_n = 1'b1;
    tick();
    check("arst_regrant_valid", gnt_valid, 1);
    check("arst_regrant_id", gnt_id, 1);

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      req          = 4'($urandom_range(0, 15));
      h_fifo_full  = ($urandom_range(0, 7) == 0);
      b_fifo_afull = ($urandom_range(0, 7) == 0);
      ack          = ($urandom_range(0, 2) == 0);
      done         = ($urandom_range(0, 29) == 0);
      tick();
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ingress_rr_sched.md
INGRESS_RR_SCHED -- requirements
Module: ingress_rr_sched

Interface
REQ-001 The block SHALL have parameter ACK_TO, default 15: maximum cycles an offered grant waits for ack before it is withdrawn.
REQ-002 The block SHALL have parameter MAX_CYC, default 4095: watchdog limit, in cycles, for one granted frame (12-bit counter).
REQ-003 Port clk, input, 1: clock; all state updates on rising edge.
REQ-004 Port arst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port req, input, 4: bit n high means PHY FIFO n holds frame data (not almost-empty).
REQ-006 Port h_fifo_full, input, 1: header FIFO full.
REQ-007 Port b_fifo_afull, input, 1: body FIFO lacks room for a 1514 B frame.
REQ-008 Port ack, input, 1: decoder accepts the offered grant (single-cycle pulse).
REQ-009 Port done, input, 1: decoder finished the granted frame (single-cycle pulse).
REQ-010 Port gnt_valid, output, 1: grant offered or active.
REQ-011 Port gnt_id, output, 2: granted port index; drives the decoder's PHY mux select.
REQ-012 Port gnt_onehot, output, 4: one-hot of gnt_id, qualified by gnt_valid (all zero when gnt_valid is low).
REQ-013 Port abort, output, 1: one-cycle pulse on watchdog expiry.
REQ-014 Port abort_cnt, output, 8: saturating count of aborts.

Function
REQ-015 The FSM SHALL have states IDLE, OFFER, ACTIVE and HOLDOFF, all registered; gnt_id, gnt_valid and abort SHALL be registered outputs.
REQ-016 Eligibility SHALL be (|req) & ~h_fifo_full & ~b_fifo_afull, sampled in IDLE only.
REQ-017 In IDLE with eligibility, the FSM SHALL select the first requesting port searching ptr+1, ptr+2, ptr+3, ptr (mod 4), load gnt_id, set gnt_valid and enter OFFER on the next cycle (latency 1 cycle).
REQ-018 In IDLE without eligibility, the FSM SHALL hold with gnt_valid=0 and gnt_id unchanged.
REQ-019 In OFFER, ack=1 SHALL move the FSM to ACTIVE, set ptr<=gnt_id and clear the watchdog.
REQ-020 In OFFER, when req[gnt_id] falls or the wait counter reaches ACK_TO, the FSM SHALL clear gnt_valid, set ptr<=gnt_id (no lockout) and enter HOLDOFF.
REQ-021 When ack and timeout or req drop coincide in OFFER, ack SHALL win.
REQ-022 A done pulse received in OFFER, IDLE or HOLDOFF SHALL be ignored.
REQ-023 In ACTIVE, gnt_valid and gnt_id SHALL hold stable regardless of req, h_fifo_full or b_fifo_afull.
REQ-024 In ACTIVE, done=1 SHALL clear gnt_valid on the next edge and move the FSM to HOLDOFF.
REQ-025 The ACTIVE watchdog SHALL count from 0; on reaching MAX_CYC it SHALL pulse abort for 1 cycle, clear gnt_valid, increment abort_cnt (saturating at 255) and enter HOLDOFF.
REQ-026 When done and watchdog expiry coincide, done SHALL win: no abort, and abort_cnt unchanged.
REQ-027 HOLDOFF SHALL last exactly 1 cycle with gnt_valid=0, then enter IDLE, giving a minimum 1-cycle gap between grants for mux settling.
REQ-028 ack received in ACTIVE, IDLE or HOLDOFF SHALL be ignored.
REQ-029 gnt_onehot SHALL be derived combinationally from the registered gnt_id and gnt_valid.

Reset
REQ-030 While arst_n=0, the block SHALL force state=IDLE, ptr=3 (so port 0 is searched first), gnt_valid=0, gnt_id=0, abort=0, abort_cnt=0, and the wait and watchdog counters to 0, immediately and asynchronously.
REQ-031 Reset asserted mid-ACTIVE SHALL drop gnt_valid without an abort pulse; after release, the block SHALL resume from IDLE one clock later.

Verification
REQ-032 After reset, req=4'b1111 with repeated ack and done SHALL produce grants to ports 0,1,2,3,0 in that order, with gaps of 1 or more cycles between grants.
REQ-033 With req=4'b0101 and h_fifo_full=1, gnt_valid SHALL stay 0; after h_fifo_full falls, gnt_id=0 SHALL be granted 1 cycle later.
REQ-034 Grant port 2 with no ack for 15 cycles SHALL withdraw gnt_valid; with req still 4'b0100, port 2 SHALL be offered again after HOLDOFF.
REQ-035 With ack, no done and MAX_CYC=20: abort SHALL pulse exactly 20 cycles after entry to ACTIVE and abort_cnt SHALL become 1; abort_cnt SHALL stop at 255 after 300 aborts.
REQ-036 done coincident with the watchdog cycle SHALL give abort=0 and abort_cnt unchanged.
REQ-037 arst_n pulsed low in ACTIVE on port 1 SHALL give all outputs 0 immediately; the next grant with req=4'b0010 SHALL be to port 1.
